// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM scanline fetcher: FSM encoding, PSRAM address width and
// the read/write opcodes driven on psram_rw.
package psram_pkg;

   localparam int unsigned PSRAM_ADDRESS_WIDTH = 23;

   localparam logic PSRAM_RW_READ  = 1'b0;
   localparam logic PSRAM_RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StSetAddr,
      StStream,
      StClose,
      StRestart
   } fetch_state_e;

endpackage

// File: rtl/psram_line_fetcher_if.sv
// PSRAM controller command/byte-stream bundle; the fetcher is the master and the PSRAM
// controller is the slave.
interface psram_line_fetcher_if
   import psram_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = PSRAM_ADDRESS_WIDTH
);

   logic                     psram_enable;
   logic                     psram_rw;
   logic                     psram_set_address;
   logic [ADDRESS_WIDTH-1:0] psram_address;
   logic                     psram_byte_valid;
   logic [7:0]               psram_data_in;

   modport master (
      output psram_enable,
      output psram_rw,
      output psram_set_address,
      output psram_address,
      input  psram_byte_valid,
      input  psram_data_in
   );

   modport slave (
      input  psram_enable,
      input  psram_rw,
      input  psram_set_address,
      input  psram_address,
      output psram_byte_valid,
      output psram_data_in
   );

endinterface

// File: rtl/line_buffer_dp.sv
// Ping-pong scanline store: simple dual-port 2*LineBytes x 8 memory with a registered read port.
// Each half is selected by a bank bit; out-of-range read indices return zero.
module line_buffer_dp #(
   parameter int unsigned LineBytes = 320,
   parameter int unsigned AddrWidth = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic                 wr_sel_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   input  logic [7:0]           wr_data_i,
   input  logic                 rd_sel_i,
   input  logic [AddrWidth-1:0] rd_addr_i,
   output logic [7:0]           rd_data_o
);

   localparam int unsigned Depth    = 2 * LineBytes;
   localparam int unsigned IdxWidth = $clog2(Depth);

   logic [7:0]          mem_q [Depth];
   logic [7:0]          rd_data_q;
   logic [IdxWidth-1:0] wr_idx;
   logic [IdxWidth-1:0] rd_idx;
   logic                rd_in_range;

   function automatic logic [IdxWidth-1:0] bank_index(input logic sel,
                                                      input logic [AddrWidth-1:0] addr);
      return sel ? IdxWidth'(LineBytes) + IdxWidth'(addr) : IdxWidth'(addr);
   endfunction

   assign wr_idx      = bank_index(wr_sel_i, wr_addr_i);
   assign rd_idx      = bank_index(rd_sel_i, rd_addr_i);
   assign rd_in_range = 32'(rd_addr_i) < LineBytes;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_idx] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= 8'h00;
      end else begin
         rd_data_q <= rd_in_range ? mem_q[rd_idx] : 8'h00;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/psram_line_fetcher.sv
// Scanline prefetch: streams LINE_BYTES from PSRAM into the back half of a ping-pong buffer
// while the VGA side reads the front half. Optional PSRAM_FETCH_STATS_EN adds overrun_count_o.
module psram_line_fetcher
   import psram_pkg::*;
#(
   parameter int unsigned LINE_BYTES    = 320,
   parameter int unsigned ADDRESS_WIDTH = PSRAM_ADDRESS_WIDTH,
   parameter int unsigned LINE_WIDTH    = 10,
   parameter int unsigned BASE_ADDRESS  = 0,
   parameter int unsigned RD_ADDR_WIDTH = 9
) (
   input  logic                     system_clock,
   input  logic                     reset_n,
   input  logic                     line_request_i,
   input  logic [LINE_WIDTH-1:0]    line_number_i,
   input  logic [RD_ADDR_WIDTH-1:0] rd_addr_i,
   output logic [7:0]               rd_data_o,
   output logic                     line_ready_o,
   output logic                     busy_o,
   output logic                     fetch_overrun_o,
`ifdef PSRAM_FETCH_STATS_EN
   output logic [15:0]              overrun_count_o,
`endif
   psram_line_fetcher_if.master     psram
);

   localparam logic [RD_ADDR_WIDTH-1:0] LastIdx = RD_ADDR_WIDTH'(LINE_BYTES - 1);

   fetch_state_e             state_q, state_d;
   logic [RD_ADDR_WIDTH-1:0] count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     front_sel_q, front_sel_d;
   logic                     overrun_q, overrun_d;
   logic                     buf_we;
   logic                     fetch_active;
   logic [31:0]              req_addr_full;

   // Wraps modulo 2^ADDRESS_WIDTH by truncation.
   assign req_addr_full = 32'(BASE_ADDRESS) + 32'(line_number_i) * 32'(LINE_BYTES);
   assign fetch_active  = state_q inside {StSetAddr, StStream, StRestart};

   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         count_q     <= '0;
         addr_q      <= '0;
         front_sel_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         front_sel_q <= front_sel_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = addr_q;
      front_sel_d = front_sel_q;
      overrun_d   = 1'b0;
      buf_we      = 1'b0;
      if (line_request_i) begin
         // A request wins over any byte arriving the same cycle; that byte belongs to the old line.
         front_sel_d = ~front_sel_q;
         addr_d      = req_addr_full[ADDRESS_WIDTH-1:0];
         count_d     = '0;
         if (fetch_active) begin
            state_d   = StRestart;
            overrun_d = 1'b1;
         end else begin
            state_d = StSetAddr;
         end
      end else begin
         unique case (state_q)
            StIdle:    state_d = StIdle;
            StSetAddr: state_d = StStream;
            StStream: begin
               if (psram.psram_byte_valid) begin
                  buf_we  = 1'b1;
                  count_d = count_q + 1'b1;
                  if (count_q == LastIdx) begin
                     state_d = StClose;
                  end
               end
            end
            StClose:   state_d = StIdle;
            StRestart: state_d = StSetAddr;
            default:   state_d = StIdle;
         endcase
      end
   end

   assign psram.psram_enable      = (state_q == StSetAddr) || (state_q == StStream);
   assign psram.psram_set_address = (state_q == StSetAddr);
   assign psram.psram_rw          = PSRAM_RW_READ;
   assign psram.psram_address     = addr_q;
   assign line_ready_o            = (state_q == StClose);
   assign busy_o                  = fetch_active;
   assign fetch_overrun_o         = overrun_q;

`ifdef PSRAM_FETCH_STATS_EN
   logic [15:0] overrun_cnt_q;

   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         overrun_cnt_q <= 16'h0000;
      end else if (overrun_d && (overrun_cnt_q != 16'hFFFF)) begin
         overrun_cnt_q <= overrun_cnt_q + 16'h0001;
      end
   end

   assign overrun_count_o = overrun_cnt_q;
`endif

   line_buffer_dp #(
      .LineBytes (LINE_BYTES),
      .AddrWidth (RD_ADDR_WIDTH)
   ) u_line_buffer (
      .clk_i     (system_clock),
      .rst_ni    (reset_n),
      .we_i      (buf_we),
      .wr_sel_i  (~front_sel_q),
      .wr_addr_i (count_q),
      .wr_data_i (psram.psram_data_in),
      .rd_sel_i  (front_sel_q),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o)
   );

endmodule

// File: tb/tb_psram_line_fetcher.sv
// Directed bench for psram_line_fetcher: a base-0 instance carries the functional tests and a
// second instance with BASE_ADDRESS=0x7FFF00 checks address wrap-around.
module tb_psram_line_fetcher;

   logic       clk;
   logic       rst_n;
   logic       line_request;
   logic [9:0] line_number;
   logic [8:0] rd_addr;
   logic [7:0] rd_data, rd_data_w;
   logic       line_ready, busy, fetch_overrun;
   logic       line_ready_w, busy_w, fetch_overrun_w;
`ifdef PSRAM_FETCH_STATS_EN
   logic [15:0] overrun_count, overrun_count_w;
`endif

   int checks   = 0;
   int errors   = 0;
   int lr_count = 0;
   int lr_base  = 0;

   psram_line_fetcher_if #(.ADDRESS_WIDTH(23)) psram_bus ();
   psram_line_fetcher_if #(.ADDRESS_WIDTH(23)) psram_bus_w ();

   psram_line_fetcher u_dut (
      .system_clock    (clk),
      .reset_n         (rst_n),
      .line_request_i  (line_request),
      .line_number_i   (line_number),
      .rd_addr_i       (rd_addr),
      .rd_data_o       (rd_data),
      .line_ready_o    (line_ready),
      .busy_o          (busy),
      .fetch_overrun_o (fetch_overrun),
`ifdef PSRAM_FETCH_STATS_EN
      .overrun_count_o (overrun_count),
`endif
      .psram           (psram_bus)
   );

   psram_line_fetcher #(
      .BASE_ADDRESS (32'h007F_FF00)
   ) u_dut_wrap (
      .system_clock    (clk),
      .reset_n         (rst_n),
      .line_request_i  (line_request),
      .line_number_i   (line_number),
      .rd_addr_i       (rd_addr),
      .rd_data_o       (rd_data_w),
      .line_ready_o    (line_ready_w),
      .busy_o          (busy_w),
      .fetch_overrun_o (fetch_overrun_w),
`ifdef PSRAM_FETCH_STATS_EN
      .overrun_count_o (overrun_count_w),
`endif
      .psram           (psram_bus_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (line_ready === 1'b1) lr_count++;
   endtask

   task automatic feed(input int total, input int n_on, input int n_off, input logic [7:0] pat);
      int sent;
      sent = 0;
      while (sent < total) begin
         for (int k = 0; k < n_on && sent < total; k++) begin
            psram_bus.psram_byte_valid = 1'b1;
            psram_bus.psram_data_in    = 8'(sent) ^ pat;
            tick();
            sent++;
         end
         psram_bus.psram_byte_valid = 1'b0;
         psram_bus.psram_data_in    = 8'hEE;
         if (sent < total) begin
            for (int k = 0; k < n_off; k++) tick();
         end
      end
      psram_bus.psram_byte_valid = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b1;
      line_request = 1'b0;
      line_number  = '0;
      rd_addr      = '0;
      psram_bus.psram_byte_valid   = 1'b0;
      psram_bus.psram_data_in      = 8'h00;
      psram_bus_w.psram_byte_valid = 1'b0;
      psram_bus_w.psram_data_in    = 8'h00;
      #1 rst_n = 1'b0;
      #3;
      check("reset_enable", 32'(psram_bus.psram_enable), 0);
      check("reset_set_address", 32'(psram_bus.psram_set_address), 0);
      check("reset_address", 32'(psram_bus.psram_address), 0);
      check("reset_rw", 32'(psram_bus.psram_rw), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_line_ready", 32'(line_ready), 0);
      check("reset_overrun", 32'(fetch_overrun), 0);
      check("reset_rd_data", 32'(rd_data), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("idle_busy", 32'(busy), 0);

      // Line 5: 5*320 = 1600 = 0x640; wrap instance 0x7FFF00+0x640 = 0x800540 -> 0x000540.
      line_number  = 10'd5;
      line_request = 1'b1;
      tick();
      line_request = 1'b0;
      check("l5_set_address", 32'(psram_bus.psram_set_address), 1);
      check("l5_enable", 32'(psram_bus.psram_enable), 1);
      check("l5_address", 32'(psram_bus.psram_address), 32'h640);
      check("l5_busy", 32'(busy), 1);
      check("l5_rw", 32'(psram_bus.psram_rw), 0);
      check("l5_wrap_address", 32'(psram_bus_w.psram_address), 32'h000540);
      tick();
      check("l5_stream_set_address", 32'(psram_bus.psram_set_address), 0);
      check("l5_stream_enable", 32'(psram_bus.psram_enable), 1);
      feed(320, 320, 0, 8'h00);
      check("l5_line_ready", 32'(line_ready), 1);
      check("l5_ready_count", 32'(lr_count), 1);
      check("l5_close_busy", 32'(busy), 0);
      check("l5_close_enable", 32'(psram_bus.psram_enable), 0);
      tick();
      check("l5_ready_one_cycle", 32'(line_ready), 0);
      check("l5_ready_count_after", 32'(lr_count), 1);

      // Swap: line 5 becomes front while line 6 starts fetching.
      line_number  = 10'd6;
      line_request = 1'b1;
      tick();
      line_request = 1'b0;
      check("l6_no_overrun_from_idle", 32'(fetch_overrun), 0);
      lr_base = lr_count;
      for (int i = 0; i < 320; i++) begin
         rd_addr = 9'(i);
         tick();
         check($sformatf("rd_l5[%0d]", i), 32'(rd_data), 32'(i & 8'hFF));
      end
      rd_addr = 9'd400;
      tick();
      check("rd_out_of_range", 32'(rd_data), 0);

      // Abort line 6 after 100 bytes with a request for line 7 (7*320 = 0x8C0).
      feed(100, 100, 0, 8'h5A);
      check("l6_busy_mid_stream", 32'(busy), 1);
      line_number  = 10'd7;
      line_request = 1'b1;
      tick();
      line_request = 1'b0;
      check("abort_overrun", 32'(fetch_overrun), 1);
      check("restart_enable_low", 32'(psram_bus.psram_enable), 0);
      check("restart_busy", 32'(busy), 1);
      check("restart_set_address", 32'(psram_bus.psram_set_address), 0);
      tick();
      check("l7_set_address", 32'(psram_bus.psram_set_address), 1);
      check("l7_address", 32'(psram_bus.psram_address), 32'h8C0);
      check("l7_overrun_one_cycle", 32'(fetch_overrun), 0);
      tick();
      feed(320, 3, 5, 8'hA5);
      check("l7_line_ready", 32'(line_ready), 1);
      check("l7_single_ready", 32'(lr_count - lr_base), 1);

      // Request while in CLOSE: line_ready still seen, next state is SET_ADDR without overrun.
      line_number  = 10'd0;
      line_request = 1'b1;
      tick();
      line_request = 1'b0;
      check("close_req_set_address", 32'(psram_bus.psram_set_address), 1);
      check("close_req_no_overrun", 32'(fetch_overrun), 0);
      check("close_req_address", 32'(psram_bus.psram_address), 0);
      for (int i = 0; i < 320; i++) begin
         rd_addr = 9'(i);
         tick();
         check($sformatf("rd_l7[%0d]", i), 32'(rd_data), 32'(8'(i) ^ 8'hA5));
      end
      check("no_ready_after_reads", 32'(lr_count - lr_base), 1);

      // Line 1023: 1023*320 = 327360 = 0x4FEC0; wrap instance (0x7FFF00+0x4FEC0) mod 2^23 = 0x04FDC0.
      line_number  = 10'd1023;
      line_request = 1'b1;
      tick();
      line_request = 1'b0;
      check("l1023_overrun", 32'(fetch_overrun), 1);
      check("l1023_address", 32'(psram_bus.psram_address), 32'h04FEC0);
      check("l1023_wrap_address", 32'(psram_bus_w.psram_address), 32'h04FDC0);
      tick();
      tick();
`ifdef PSRAM_FETCH_STATS_EN
      check("overrun_count", 32'(overrun_count), 2);
`endif
      feed(10, 10, 0, 8'h00);
      check("pre_reset_busy", 32'(busy), 1);
      check("pre_reset_enable", 32'(psram_bus.psram_enable), 1);

      // Asynchronous reset mid-stream.
      rst_n = 1'b0;
      #1;
      check("rst_enable", 32'(psram_bus.psram_enable), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_line_ready", 32'(line_ready), 0);
      check("rst_set_address", 32'(psram_bus.psram_set_address), 0);
      check("rst_wrap_enable", 32'(psram_bus_w.psram_enable), 0);
`ifdef PSRAM_FETCH_STATS_EN
      check("rst_overrun_count", 32'(overrun_count), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", 32'(busy), 0);
      check("post_reset_address", 32'(psram_bus.psram_address), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
